// File: rtl/hdlc_pkg.sv
// Shared definitions for the HDLC receive deframer.
// Holds the frame-tracking state type and the default stuffing run length
// and payload word width used by the deframer, its interface and its packer.
package hdlc_pkg;

    localparam int unsigned HDLC_STUFF_LEN = 5;
    localparam int unsigned HDLC_WIDTH     = 8;

    typedef enum logic [1:0] {
        StHunt    = 2'd0,
        StFlagged = 2'd1,
        StFrame   = 2'd2
    } frame_state_e;

endpackage

// File: rtl/hdlc_rx_deframer_if.sv
// Bit-stream input and event/word output bundle of the HDLC receive deframer.
// master: the line sampler side (drives in/in_valid, observes results).
// slave:  the deframer (consumes in/in_valid, drives every result signal).
// Signals:
//   in, in_valid            serial line bit and its qualifier
//   disc, flag, err         stuffed-zero / flag / abort-run pulses
//   data_out, data_valid    packed payload word (first bit in bit 0) and strobe
//   frame_start, frame_end  frame boundary pulses; frame_resid = dropped tail bits
//   frame_abort             error run inside an open frame
// Optional (HDLC_RX_STATS_EN): frames_ok, frames_aborted saturating counters.
interface hdlc_rx_deframer_if import hdlc_pkg::*; #(
    parameter int unsigned WIDTH = HDLC_WIDTH
) ();

    logic                     in;
    logic                     in_valid;
    logic                     disc;
    logic                     flag;
    logic                     err;
    logic [WIDTH-1:0]         data_out;
    logic                     data_valid;
    logic                     frame_start;
    logic                     frame_end;
    logic [$clog2(WIDTH)-1:0] frame_resid;
    logic                     frame_abort;
`ifdef HDLC_RX_STATS_EN
    logic [15:0]              frames_ok;
    logic [15:0]              frames_aborted;
`endif

    modport master (
        output in, in_valid,
        input  disc, flag, err, data_out, data_valid,
        input  frame_start, frame_end, frame_resid, frame_abort
`ifdef HDLC_RX_STATS_EN
        , input frames_ok, frames_aborted
`endif
    );

    modport slave (
        input  in, in_valid,
        output disc, flag, err, data_out, data_valid,
        output frame_start, frame_end, frame_resid, frame_abort
`ifdef HDLC_RX_STATS_EN
        , output frames_ok, frames_aborted
`endif
    );

endinterface

// File: rtl/hdlc_word_packer.sv
// Packs committed payload bits LSB-first into WIDTH-bit words.
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   bit_i          bit being committed
//   commit_i       bit_i is the next payload bit
//   clear_i        drop the partial word (frame closed or aborted)
//   data_o         last completed word, held until the next one completes
//   data_valid_o   one-cycle strobe: data_o was just updated
//   count_o        bits currently held in the partial word
module hdlc_word_packer import hdlc_pkg::*; #(
    parameter int unsigned WIDTH = HDLC_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     bit_i,
    input  logic                     commit_i,
    input  logic                     clear_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     data_valid_o,
    output logic [$clog2(WIDTH)-1:0] count_o
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LastPos = CW'(WIDTH - 1);

    logic [WIDTH-1:0] word_q, word_d;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] data_q;
    logic             dv_q;

    always_comb begin
        word_d          = word_q;
        word_d[count_q] = bit_i;
    end

    // Stale bits from an earlier partial word are always overwritten before
    // the word completes, so clear only needs to reset the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q  <= '0;
            count_q <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            if (clear_i) begin
                count_q <= '0;
            end else if (commit_i) begin
                word_q <= word_d;
                if (count_q == LastPos) begin
                    data_q  <= word_d;
                    dv_q    <= 1'b1;
                    count_q <= '0;
                end else begin
                    count_q <= count_q + CW'(1);
                end
            end
        end
    end

    assign data_o       = data_q;
    assign data_valid_o = dv_q;
    assign count_o      = count_q;

endmodule

// File: rtl/hdlc_rx_deframer.sv
// HDLC-style receive deframer with configurable stuffing run length.
// Classifies each accepted line bit (stuffed zero, flag, abort run, payload),
// delays payload bits by STUFF_LEN+2 so flag prefixes never reach the packer,
// tracks frame boundaries and packs payload LSB-first into WIDTH-bit words.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    hdlc_rx_deframer_if slave modport (line input, event/word outputs)
// Build option HDLC_RX_STATS_EN adds frames_ok / frames_aborted counters.
module hdlc_rx_deframer import hdlc_pkg::*; #(
    parameter int unsigned STUFF_LEN = HDLC_STUFF_LEN,
    parameter int unsigned WIDTH     = HDLC_WIDTH
) (
    input logic               clk,
    input logic               reset,
    hdlc_rx_deframer_if.slave bus
);

    localparam int unsigned D  = STUFF_LEN + 2;
    localparam int unsigned OW = $clog2(STUFF_LEN + 3);
    localparam int unsigned FW = $clog2(D + 1);
    localparam int unsigned RW = $clog2(WIDTH);

    localparam logic [OW-1:0] OnesStuff = OW'(STUFF_LEN);
    localparam logic [OW-1:0] OnesFlag  = OW'(STUFF_LEN + 1);
    localparam logic [OW-1:0] OnesErr   = OW'(STUFF_LEN + 2);
    localparam logic [FW-1:0] FillFull  = FW'(D);

    logic [OW-1:0] ones_q;
    logic [D-1:0]  dl_q;      // newest bit at [0], oldest at [D-1] once full
    logic [FW-1:0] fill_q;
    frame_state_e  state_q;

    logic          disc_q, flag_q, err_q;
    logic          frame_start_q, frame_end_q, frame_abort_q;
    logic [RW-1:0] frame_resid_q;

    logic          ev_err, ev_push, ev_disc, ev_flag;
    logic          pk_commit, pk_clear;
    logic [RW-1:0] pk_count;

    always_comb begin
        ev_err  = 1'b0;
        ev_push = 1'b0;
        ev_disc = 1'b0;
        ev_flag = 1'b0;
        if (bus.in_valid) begin
            if (bus.in) begin
                if (ones_q >= OnesFlag) ev_err = 1'b1;
                else                    ev_push = 1'b1;
            end else begin
                if (ones_q == OnesStuff)     ev_disc = 1'b1;
                else if (ones_q == OnesFlag) ev_flag = 1'b1;
                else if (ones_q < OnesStuff) ev_push = 1'b1;
                // ones_q == OnesErr: the terminating zero is silently dropped
            end
        end
    end

    // Bits leaving the delay line are payload only once a frame is open.
    assign pk_commit = ev_push && (fill_q == FillFull) && (state_q != StHunt);
    assign pk_clear  = ev_flag || ev_err;

    hdlc_word_packer #(
        .WIDTH (WIDTH)
    ) u_packer (
        .clk          (clk),
        .reset        (reset),
        .bit_i        (dl_q[D-1]),
        .commit_i     (pk_commit),
        .clear_i      (pk_clear),
        .data_o       (bus.data_out),
        .data_valid_o (bus.data_valid),
        .count_o      (pk_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ones_q        <= '0;
            dl_q          <= '0;
            fill_q        <= '0;
            state_q       <= StHunt;
            disc_q        <= 1'b0;
            flag_q        <= 1'b0;
            err_q         <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_abort_q <= 1'b0;
            frame_resid_q <= '0;
        end else begin
            disc_q        <= ev_disc;
            flag_q        <= ev_flag;
            err_q         <= ev_err;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_abort_q <= 1'b0;
            frame_resid_q <= '0;

            if (bus.in_valid) begin
                if (!bus.in)                ones_q <= '0;
                else if (ones_q != OnesErr) ones_q <= ones_q + OW'(1);
            end

            if (ev_push) begin
                dl_q <= {dl_q[D-2:0], bus.in};
                if (fill_q != FillFull) fill_q <= fill_q + FW'(1);
            end else if (ev_flag || ev_err) begin
                fill_q <= '0;
            end

            case (state_q)
                StHunt: begin
                    if (ev_flag) state_q <= StFlagged;
                end
                StFlagged: begin
                    if (ev_err) begin
                        frame_abort_q <= 1'b1;
                        state_q       <= StHunt;
                    end else if (pk_commit) begin
                        frame_start_q <= 1'b1;
                        state_q       <= StFrame;
                    end
                end
                StFrame: begin
                    if (ev_flag) begin
                        frame_end_q   <= 1'b1;
                        frame_resid_q <= pk_count;
                        state_q       <= StFlagged;
                    end else if (ev_err) begin
                        frame_abort_q <= 1'b1;
                        state_q       <= StHunt;
                    end
                end
                default: state_q <= StHunt;
            endcase
        end
    end

    assign bus.disc        = disc_q;
    assign bus.flag        = flag_q;
    assign bus.err         = err_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_end   = frame_end_q;
    assign bus.frame_resid = frame_resid_q;
    assign bus.frame_abort = frame_abort_q;

`ifdef HDLC_RX_STATS_EN
    logic [15:0] frames_ok_q, frames_aborted_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frames_ok_q      <= '0;
            frames_aborted_q <= '0;
        end else begin
            if (state_q == StFrame && ev_flag && pk_count == '0 &&
                frames_ok_q != 16'hFFFF) begin
                frames_ok_q <= frames_ok_q + 16'd1;
            end
            if (state_q != StHunt && ev_err && frames_aborted_q != 16'hFFFF) begin
                frames_aborted_q <= frames_aborted_q + 16'd1;
            end
        end
    end

    assign bus.frames_ok      = frames_ok_q;
    assign bus.frames_aborted = frames_aborted_q;
`endif

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Self-checking bench for hdlc_rx_deframer: directed scenarios plus random
// framed and raw bit streams against a queue-based reference model.
module tb_hdlc_rx_deframer;
    import hdlc_pkg::*;

    localparam int L0 = 5;
    localparam int W0 = 8;
    localparam int D0 = L0 + 2;
    localparam int L1 = 3;
    localparam int W1 = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hdlc_rx_deframer_if #(.WIDTH(W0)) bus0 ();
    hdlc_rx_deframer_if #(.WIDTH(W1)) bus1 ();

    hdlc_rx_deframer #(.STUFF_LEN(L0), .WIDTH(W0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    hdlc_rx_deframer #(.STUFF_LEN(L1), .WIDTH(W1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state: run length, delay queue, frame phase, packer.
    int         m_ones;
    bit         m_dl[$];
    int         m_st;       // 0 hunting, 1 after flag, 2 inside frame
    int         m_pk_n;
    logic [7:0] m_word;
    logic [7:0] m_dout;
    bit e_disc, e_flag, e_err, e_dv, e_fs, e_fe, e_fa;
    int e_resid;

    // Observed-event tallies for directed scenario checks.
    int n_disc, n_flag, n_err, n_dv, n_fs, n_fe, n_fa;
    logic [7:0] last_word;
    int last_resid;
    int s_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ones = 0;
        m_dl.delete();
        m_st   = 0;
        m_pk_n = 0;
        m_word = '0;
        m_dout = '0;
    endtask

    task automatic clear_obs();
        n_disc = 0; n_flag = 0; n_err = 0; n_dv = 0;
        n_fs = 0; n_fe = 0; n_fa = 0;
        last_word = 'x; last_resid = -1;
    endtask

    task automatic model_commit(input bit c);
        if (m_st != 0) begin
            if (m_st == 1) begin
                e_fs = 1'b1;
                m_st = 2;
            end
            m_word[m_pk_n] = c;
            m_pk_n++;
            if (m_pk_n == W0) begin
                e_dv   = 1'b1;
                m_dout = m_word;
                m_pk_n = 0;
            end
        end
    endtask

    task automatic model_push(input bit c);
        m_dl.push_back(c);
        if (m_dl.size() > D0) model_commit(m_dl.pop_front());
    endtask

    task automatic model_bit(input bit b);
        if (b) begin
            if (m_ones + 1 >= L0 + 2) begin
                e_err = 1'b1;
                m_dl.delete();
                m_ones = L0 + 2;
                if (m_st != 0) begin
                    e_fa   = 1'b1;
                    m_st   = 0;
                    m_pk_n = 0;
                end
            end else begin
                m_ones++;
                model_push(1'b1);
            end
        end else begin
            if (m_ones == L0) begin
                e_disc = 1'b1;
            end else if (m_ones == L0 + 1) begin
                e_flag = 1'b1;
                m_dl.delete();
                if (m_st == 2) begin
                    e_fe    = 1'b1;
                    e_resid = m_pk_n;
                end
                m_st   = 1;
                m_pk_n = 0;
            end else if (m_ones < L0) begin
                model_push(1'b0);
            end
            m_ones = 0;
        end
    endtask

    task automatic send0(input bit b, input bit v);
        bus0.in       = b;
        bus0.in_valid = v;
        @(posedge clk);
        #1;
        {e_disc, e_flag, e_err, e_dv, e_fs, e_fe, e_fa} = '0;
        e_resid = 0;
        if (v) model_bit(b);
        chk("pulses{disc,flag,err,dv,fs,fe,fa}",
            32'({bus0.disc, bus0.flag, bus0.err, bus0.data_valid,
                 bus0.frame_start, bus0.frame_end, bus0.frame_abort}),
            32'({e_disc, e_flag, e_err, e_dv, e_fs, e_fe, e_fa}));
        if (e_dv) chk("data_out", 32'(bus0.data_out), 32'(m_dout));
        if (e_fe) chk("frame_resid", 32'(bus0.frame_resid), 32'(e_resid));
        n_disc += int'(bus0.disc);
        n_flag += int'(bus0.flag);
        n_err  += int'(bus0.err);
        n_dv   += int'(bus0.data_valid);
        n_fs   += int'(bus0.frame_start);
        n_fe   += int'(bus0.frame_end);
        n_fa   += int'(bus0.frame_abort);
        if (bus0.data_valid) last_word = bus0.data_out;
        if (bus0.frame_end) last_resid = int'(bus0.frame_resid);
    endtask

    task automatic send_flag0();
        send0(1'b0, 1'b1);
        repeat (6) send0(1'b1, 1'b1);
        send0(1'b0, 1'b1);
        s_cnt = 0;
    endtask

    // Payload bit with transmitter-side zero stuffing and optional idle gaps.
    task automatic send_data0(input bit b, input bit gaps);
        if (gaps && $urandom_range(0, 9) == 0) send0(1'($urandom), 1'b0);
        send0(b, 1'b1);
        if (b) begin
            s_cnt++;
            if (s_cnt == L0) begin
                send0(1'b0, 1'b1);
                s_cnt = 0;
            end
        end else begin
            s_cnt = 0;
        end
    endtask

    task automatic send_byte0(input logic [7:0] v, input bit gaps);
        for (int i = 0; i < 8; i++) send_data0(v[i], gaps);
    endtask

    task automatic send1(input bit b);
        bus1.in       = b;
        bus1.in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] byte_v;
        logic [2:0] exp1 [15];
        bit         seq1 [15];
        int         nb;
        int         nx;

        seq1 = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1};
        exp1 = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010,
                 3'b000, 3'b000, 3'b000, 3'b100,
                 3'b000, 3'b000, 3'b000, 3'b000, 3'b001};

        reset = 1'b1;
        bus0.in = 1'b0; bus0.in_valid = 1'b0;
        bus1.in = 1'b0; bus1.in_valid = 1'b0;
        model_reset();
        clear_obs();
        s_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs",
            32'({bus0.disc, bus0.flag, bus0.err, bus0.data_valid, bus0.frame_start,
                 bus0.frame_end, bus0.frame_abort, bus0.frame_resid, bus0.data_out}), 32'd0);
        chk("reset_state", 32'(dut0.state_q), 32'(StHunt));
        reset = 1'b0;

        // STUFF_LEN=3, WIDTH=4 instance: flag, stuffed zero, abort run.
        for (int i = 0; i < 15; i++) begin
            send1(seq1[i]);
            chk("dut1_{disc,flag,err}", 32'({bus1.disc, bus1.flag, bus1.err}), 32'(exp1[i]));
        end
        bus1.in_valid = 1'b0;

        // Opening flag from reset.
        clear_obs();
        send0(1'b0, 1'b1);
        repeat (6) send0(1'b1, 1'b1);
        send0(1'b0, 1'b1);
        chk("flag_after_8th", 32'(bus0.flag), 32'd1);
        chk("flag_count", 32'(n_flag), 32'd1);
        chk("no_disc_err", 32'(n_disc + n_err), 32'd0);
        chk("state_flagged", 32'(dut0.state_q), 32'(StFlagged));

        // 0xA5 frame.
        clear_obs();
        send_flag0();
        send_byte0(8'hA5, 1'b0);
        send_flag0();
        chk("a5_frame_start", 32'(n_fs), 32'd1);
        chk("a5_dv_count", 32'(n_dv), 32'd1);
        chk("a5_word", 32'(last_word), 32'hA5);
        chk("a5_frame_end", 32'(n_fe), 32'd1);
        chk("a5_resid", 32'(last_resid), 32'd0);

        // 0xFF frame needing one stuffed zero.
        clear_obs();
        send_flag0();
        send_byte0(8'hFF, 1'b0);
        send_flag0();
        chk("ff_disc", 32'(n_disc), 32'd1);
        chk("ff_dv_count", 32'(n_dv), 32'd1);
        chk("ff_word", 32'(last_word), 32'hFF);
        chk("ff_resid", 32'(last_resid), 32'd0);

        // 0x0F then an abort run of 8 ones.
        clear_obs();
        send_flag0();
        send_byte0(8'h0F, 1'b0);
        repeat (8) send0(1'b1, 1'b1);
        send0(1'b0, 1'b1);
        chk("abort_err_count", 32'(n_err), 32'd2);
        chk("abort_count", 32'(n_fa), 32'd1);
        chk("abort_no_dv", 32'(n_dv), 32'd0);
        chk("state_hunt", 32'(dut0.state_q), 32'(StHunt));

        // Short frame: 3 residual bits.
        clear_obs();
        send_flag0();
        send_data0(1'b1, 1'b0); send_data0(1'b0, 1'b0); send_data0(1'b1, 1'b0);
        send_flag0();
        chk("short_frame_end", 32'(n_fe), 32'd1);
        chk("short_resid", 32'(last_resid), 32'd3);
        chk("short_no_dv", 32'(n_dv), 32'd0);

        // Stalled input leaves everything unchanged.
        repeat (5) send0(1'($urandom), 1'b0);

        // Reset mid-frame with a run of 5 ones pending.
        clear_obs();
        send_flag0();
        send_byte0(8'h3C, 1'b0);
        send_byte0(8'h01, 1'b0);
        repeat (5) send0(1'b1, 1'b1);
        chk("pre_reset_state", 32'(dut0.state_q), 32'(StFrame));
        reset = 1'b1;
        #1;
        chk("midreset_outputs",
            32'({bus0.disc, bus0.flag, bus0.err, bus0.data_valid, bus0.frame_start,
                 bus0.frame_end, bus0.frame_abort, bus0.frame_resid, bus0.data_out}), 32'd0);
        chk("midreset_state", 32'(dut0.state_q), 32'(StHunt));
        @(posedge clk);
        #1;
        chk("midreset_no_abort", 32'(bus0.frame_abort), 32'd0);
        reset = 1'b0;
        model_reset();
        send0(1'b0, 1'b1);
        chk("post_reset_no_disc", 32'(bus0.disc), 32'd0);

        // Random framed traffic with idle gaps and occasional aborts.
        for (int f = 0; f < 30; f++) begin
            send_flag0();
            nb = $urandom_range(1, 4);
            for (int k = 0; k < nb; k++) begin
                byte_v = 8'($urandom);
                send_byte0(byte_v, 1'b1);
            end
            nx = $urandom_range(0, 7);
            for (int k = 0; k < nx; k++) send_data0(1'($urandom), 1'b1);
            if ($urandom_range(0, 9) == 0) repeat (8) send0(1'b1, 1'b1);
        end
        send_flag0();

        // Raw one-heavy random stream.
        for (int i = 0; i < 1500; i++) begin
            send0(($urandom_range(0, 9) < 7), ($urandom_range(0, 6) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hdlc_rx_deframer.md
# hdlc_rx_deframer

Parametrised HDLC-style receive deframer for a serial bit stream, the successor to the fixed 6-ones flag/discard/error recogniser. It detects flags, stuffed-zero discards and aborts for a configurable stuffing run length. It removes stuffed bits, tracks frame boundaries and packs the destuffed payload LSB-first into WIDTH-bit words. It sits directly behind the line bit-sampler, and its word output feeds the frame buffer.

## Interface
- STUFF_LEN, default 5: consecutive data ones after which a 0 is stuffed; flag is 0, then STUFF_LEN+1 ones, then 0; abort/error is STUFF_LEN+2 or more ones.
- WIDTH, default 8: payload word width in bits.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in  in  1  serial line bit
- in_valid  in  1  qualifies `in`; when low, no state advances
- disc  out  1  one-cycle pulse: stuffed zero removed
- flag  out  1  one-cycle pulse: flag recognised
- err  out  1  pulse per accepted 1 while the run is at least STUFF_LEN+2
- data_out  out  WIDTH  packed payload word, first received bit in bit 0
- data_valid  out  1  one-cycle pulse: data_out holds a complete word
- frame_start  out  1  pulse: first payload bit of a frame committed
- frame_end  out  1  pulse: closing flag of a frame with payload
- frame_resid  out  $clog2(WIDTH)  bits left in the partial word at frame_end; these bits are discarded
- frame_abort  out  1  pulse: error run inside FLAGGED or FRAME

## Operation
- Run counter `ones`, saturating at STUFF_LEN+2, reset value 0. A reset start behaves as if a 0 preceded the first bit.
- Each accepted bit (in_valid=1) is handled by the first matching rule:
  - in=1 and ones reaches STUFF_LEN+2 (or is already there): err. The delay line is flushed.
  - in=1 otherwise: ones++. The bit enters the delay line.
  - in=0 and ones==STUFF_LEN: disc. The bit is dropped and ones is cleared.
  - in=0 and ones==STUFF_LEN+1: flag. The delay line is flushed, the bit is dropped and ones is cleared.
  - in=0 and ones<STUFF_LEN: the bit enters the delay line and ones is cleared.
  - in=0 and ones==STUFF_LEN+2: ones is cleared. No pulse, and the bit is dropped.
- Delay line:
  - Depth D=STUFF_LEN+2, with a fill count.
  - A push while full commits the oldest bit to the packer.
  - A flush empties it; the flag-prefix bits are never committed.
- Frame FSM, states HUNT, FLAGGED and FRAME. Reset state is HUNT.
  - HUNT: on flag, go to FLAGGED. Committed bits are ignored.
  - FLAGGED: on flag, stay in FLAGGED. On the first commit, assert frame_start and go to FRAME. On err, assert frame_abort and go to HUNT.
  - FRAME: on flag, assert frame_end and frame_resid=packer count, clear the packer and go to FLAGGED. On err, assert frame_abort, clear the packer and go to HUNT.
- Packer:
  - The k-th committed bit goes to position k.
  - At WIDTH bits, data_valid pulses and the count returns to 0.
  - A word completing on the same edge as frame_start is legal.
- disc, flag and err pulse independently of frame state.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Every pulse is high for exactly the one cycle following the clk edge that samples the completing bit.
- in_valid=0 deasserts all pulses and leaves all state unchanged.
- A payload bit commits D accepted bits after its own acceptance. data_valid asserts in the cycle after the edge that commits the WIDTH-th bit.
- The closing flag asserts flag and frame_end in the same cycle. A word completed by that same commit is impossible, because the flush precedes any commit.
- Asserting reset mid-frame clears everything immediately, with no frame_abort. The first accepted bit after release is evaluated with ones=0.

## Configuration
- HDLC_RX_STATS_EN defined: adds outputs frames_ok[15:0] and frames_aborted[15:0].
  - Saturating counters incremented on frame_end with frame_resid==0 and on frame_abort respectively.
  - Reset value 0.
- HDLC_RX_STATS_EN undefined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- Shared package hdlc_pkg holds:
  - the frame state enum (HUNT, FLAGGED, FRAME)
  - default constants HDLC_STUFF_LEN=5 and HDLC_WIDTH=8
- One sub-module, hdlc_word_packer (parameter WIDTH). It takes bit plus commit plus clear, and produces data_out, data_valid and count.
- Run counter, delay line and FSM stay in the top level.

## Test plan
All scenarios use defaults unless noted, with in_valid held high.

- Reset, then feed 0,1,1,1,1,1,1,0 -> flag=1 for one cycle after the 8th bit; disc=err=0; FSM in FLAGGED.
- Flag, byte 0xA5 LSB-first (1,0,1,0,0,1,0,1), flag -> frame_start once, data_valid with data_out=8'hA5, frame_end with frame_resid=0.
- Flag, payload 0xFF sent as 1,1,1,1,1,0,1,1,1, flag -> disc after the stuffed 0, single word 8'hFF, frame_end resid 0.
- Flag, 0x0F, then 8 ones, then 0 -> err on the 7th and 8th ones, frame_abort once with the first err, no data_valid for the partial word, FSM in HUNT.
- Flag, bits 1,0,1, flag -> frame_end with frame_resid=3, no data_valid. Reset asserted mid-frame -> all outputs 0, no frame_abort.
- STUFF_LEN=3, WIDTH=4: 0,1,1,1,1,0 gives flag; 1,1,1,0 gives disc; 1,1,1,1,1 gives err on the 5th one.
